serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised bit-serial adder: one full-adder stage plus a carry flip-flop adds two WIDTH-bit operands LSB-first, one bit per clock.
- Successor to the single-bit combinational full adder. Used where area matters more than latency, e.g. accumulator datapaths and lab-level ALU building blocks.
- Start/busy/done handshake; the result is held stable until the next operation is accepted.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising edge in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- sum  output  WIDTH  result, valid while done=1 and held afterwards.
- cout  output  1  carry out of the MSB.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: synchronous, active-high; clock and reset are a single clk and a single reset port.
- Reset values: sum=0, cout=0, overflow=0, busy=0, done=0; state=IDLE; internal shift registers, carry flip-flop and bit counter cleared. Reset overrides all other inputs on the same edge.
- States: IDLE, RUN, DONE.
- IDLE, start=1: capture a, b into shift registers and cin into the carry flip-flop; clear the bit counter; go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - s_i = a_i ^ b_i ^ c.
  - c <= (a_i & b_i) | (c & (a_i ^ b_i)).
  - s_i shifts into the sum register from the MSB end; the operand registers shift right; the counter increments.
  - Before updating c on bit WIDTH-1, save the current c as the carry into the MSB.
- RUN exit: after WIDTH processing edges, go to DONE.
  - sum, cout, overflow update on the same edge.
  - busy=0 and done=1 for that one cycle.
- Latency: done is high in the cycle beginning exactly WIDTH+1 edges after the accepting edge.
- DONE: one cycle long.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operations, throughput WIDTH+1 clocks).
  - Otherwise go to IDLE.
- start while busy=1: ignored; operands are not recaptured and no state change occurs.
- Result hold: sum, cout and overflow hold their values until the next DONE.
  - They do not change during a following RUN; only the internal shadow register shifts.
- Reset during RUN: operation aborted. No done pulse. Outputs return to reset values on that edge.
- Inputs a, b, cin may change freely when not being accepted.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands.
  - When sub=1: the b shift register loads ~b, and the carry flip-flop loads 1 (cin ignored).
  - Result: sum = a - b modulo 2^WIDTH; cout=1 means no borrow; overflow is the signed subtraction overflow.
  - sub=0 behaves as the base block.
- Undefined: no sub port; addition only; identical timing.

Test Plan:
- WIDTH=8, reset 2 cycles, then start with a=0x0F, b=0x01, cin=0 -> done exactly 9 edges after accept; sum=0x10, cout=0, overflow=0; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01.
- Accept a=0x12, b=0x34; pulse start with a=0xAA at cycle 3 of RUN -> ignored; sum=0x46. Assert start during DONE with a=0x01, b=0x01 -> accepted; next done gives sum=0x02 while sum holds 0x46 throughout RUN.
- Accept a=0x55, b=0x55; assert reset at cycle 4 of RUN -> no done pulse; sum=0, busy=0, state IDLE; a new start then completes normally.
- WIDTH=4 exhaustive, all a, b, cin (512 cases) -> {cout,sum} matches a+b+cin and overflow matches signed reference.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8, sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, overflow=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
//   start    - request (master -> slave), sampled in IDLE or DONE
//   a, b     - WIDTH-bit operands (master -> slave)
//   cin      - carry-in (master -> slave)
//   sub      - subtract select, present only when SERIAL_ADDER_SUB_EN is defined
//   sum      - WIDTH-bit result (slave -> master), held until the next completion
//   cout     - carry out of the MSB (slave -> master)
//   overflow - signed overflow (slave -> master)
//   busy     - high while bits are being processed (slave -> master)
//   done     - one-cycle completion pulse (slave -> master)
// Optional feature macro: SERIAL_ADDER_SUB_EN.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input sum, cout, overflow, busy, done);
  modport slave  (input start, a, b, cin, sub, output sum, cout, overflow, busy, done);
`else
  modport master (output start, a, b, cin, input sum, cout, overflow, busy, done);
  modport slave  (input start, a, b, cin, output sum, cout, overflow, busy, done);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder stage plus a carry flip-flop,
// processing WIDTH-bit operands LSB-first at one bit per clock.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - serial_adder_if.slave (start/a/b/cin[/sub] in, sum/cout/overflow/busy/done out)
// Timing: the accepting edge loads the operands, WIDTH further edges process
// the bits, and the last of those raises done for one cycle.  A start seen in
// DONE is accepted like one seen in IDLE, giving a WIDTH+1 clock throughput.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input; sub=1 loads
// ~b and forces the carry-in to 1 so the result is a - b.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          reset,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the low WIDTH-1 result bits while the next operation runs, so the
  // visible sum stays untouched until completion.
  logic [WIDTH-2:0] shadow_q, shadow_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             carry_nx;
  logic [WIDTH-1:0] shift_w;
  logic             b_load_inv;
  logic             carry_load;

  // Full-adder stage on the current LSBs.
  assign bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign carry_nx = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  // New bit enters at the MSB end; on the final bit this is the complete sum.
  assign shift_w  = {bit_s, shadow_q};

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load_inv = bus.sub;
  assign carry_load = bus.sub | bus.cin;
`else
  assign b_load_inv = 1'b0;
  assign carry_load = bus.cin;
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    shadow_d = shadow_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = b_load_inv ? ~bus.b : bus.b;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        shadow_d = shift_w[WIDTH-1:1];
        carry_d  = carry_nx;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q is still the carry into the MSB here, carry_nx the carry out.
          sum_d   = shift_w;
          cout_d  = carry_nx;
          ovf_d   = carry_q ^ carry_nx;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      shadow_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      shadow_q <= shadow_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench for serial_adder at WIDTH=8 plus an
// exhaustive sweep of a WIDTH=4 instance.  Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_serial_adder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // Results of the latest do_op8 call.
  logic [7:0] r_sum;
  logic       r_cout;
  logic       r_ovf;
  int         r_lat;   // edges from the accepting edge (inclusive) to done
  int         r_busy;  // cycles with busy=1 before done

  // Launch one WIDTH=8 operation and wait (bounded) for done.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    bus8.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = sub;
`else
    if (sub) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
    @(negedge clk);
    bus8.start = 1'b0;
    r_lat = 1;
    r_busy = 0;
    while (bus8.done !== 1'b1 && r_lat < 40) begin
      if (bus8.busy === 1'b1) r_busy++;
      @(negedge clk);
      r_lat++;
    end
    r_sum = bus8.sum;
    r_cout = bus8.cout;
    r_ovf = bus8.overflow;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus8.sum, bus8.cout, bus8.overflow, bus8.busy, bus8.done} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state got sum=%h cout=%b ovf=%b busy=%b done=%b want all zero",
               bus8.sum, bus8.cout, bus8.overflow, bus8.busy, bus8.done);
    end
  endtask

  task automatic test_basic;
    do_op8(8'h0F, 8'h01, 1'b0, 1'b0);
    $display("op a=0f b=01 cin=0 -> sum=%h cout=%b ovf=%b lat=%0d busy=%0d",
             r_sum, r_cout, r_ovf, r_lat, r_busy);
    checks++;
    if (r_lat !== 9) begin
      failures++;
      $display("FAIL basic_latency got %0d want 9", r_lat);
    end
    checks++;
    if (r_busy !== 8) begin
      failures++;
      $display("FAIL basic_busy_cycles got %0d want 8", r_busy);
    end
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h10, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_result got sum=%h cout=%b ovf=%b want 10 0 0", r_sum, r_cout, r_ovf);
    end
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b0 || bus8.sum !== 8'h10) begin
      failures++;
      $display("FAIL basic_hold got done=%b sum=%h want 0 10", bus8.done, bus8.sum);
    end
  endtask

  task automatic test_carry;
    logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h00};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h00};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [9:0] vexp [3] = '{{8'h00, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1}, {8'h01, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      do_op8(va[i], vb[i], vc[i], 1'b0);
      $display("op a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b", va[i], vb[i], vc[i],
               r_sum, r_cout, r_ovf);
      checks++;
      if ({r_sum, r_cout, r_ovf} !== vexp[i] || r_lat !== 9) begin
        failures++;
        $display("FAIL carry_case%0d got sum=%h cout=%b ovf=%b lat=%0d want {sum,cout,ovf}=%h lat=9",
                 i, r_sum, r_cout, r_ovf, r_lat, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int held_bad;
    // start with a=AA during RUN must be ignored.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hAA;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 4;
    while (bus8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("op a=12 b=34 (start a=aa in RUN) -> sum=%h lat=%0d", bus8.sum, lat);
    checks++;
    if (bus8.sum !== 8'h46 || lat !== 9) begin
      failures++;
      $display("FAIL ignore_start got sum=%h lat=%0d want 46 9", bus8.sum, lat);
    end
    // Start while in DONE: accepted on the next edge.
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    checks++;
    if (bus8.busy !== 1'b1) begin
      failures++;
      $display("FAIL done_accept got busy=%b want 1", bus8.busy);
    end
    lat = 1;
    held_bad = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      if (bus8.sum !== 8'h46) held_bad++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (held_bad !== 0) begin
      failures++;
      $display("FAIL sum_hold_in_run got %0d changed cycles want 0", held_bad);
    end
    $display("op a=01 b=01 (back-to-back) -> sum=%h lat=%0d", bus8.sum, lat);
    checks++;
    if (bus8.sum !== 8'h02 || lat !== 9) begin
      failures++;
      $display("FAIL back_to_back got sum=%h lat=%0d want 02 9", bus8.sum, lat);
    end
  endtask

  task automatic test_reset_abort;
    int saw_done;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h55; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus8.sum, bus8.cout, bus8.overflow, bus8.busy, bus8.done} !== 12'h000) begin
      failures++;
      $display("FAIL abort_state got sum=%h cout=%b ovf=%b busy=%b done=%b want all zero",
               bus8.sum, bus8.cout, bus8.overflow, bus8.busy, bus8.done);
    end
    saw_done = 0;
    repeat (12) begin
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) saw_done++;
      @(negedge clk);
    end
    checks++;
    if (saw_done !== 0) begin
      failures++;
      $display("FAIL abort_no_done got %0d active cycles want 0", saw_done);
    end
    do_op8(8'h03, 8'h04, 1'b0, 1'b0);
    $display("op a=03 b=04 after abort -> sum=%h lat=%0d", r_sum, r_lat);
    checks++;
    if (r_sum !== 8'h07 || r_lat !== 9) begin
      failures++;
      $display("FAIL after_abort got sum=%h lat=%0d want 07 9", r_sum, r_lat);
    end
  endtask

  task automatic test_exhaustive4;
    int lat;
    int bad = 0;
    logic [4:0] ref_full;
    logic       ref_ovf;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          bus4.start = 1'b1;
          bus4.a = 4'(ia);
          bus4.b = 4'(ib);
          bus4.cin = 1'(ic);
          @(negedge clk);
          bus4.start = 1'b0;
          lat = 1;
          while (bus4.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
          end
          ref_full = 5'(ia) + 5'(ib) + 5'(ic);
          ref_ovf = (ia[3] == ib[3]) && (ref_full[3] != ia[3]);
          checks++;
          if ({bus4.cout, bus4.sum} !== ref_full || bus4.overflow !== ref_ovf || lat !== 5) begin
            failures++;
            bad++;
            $display("FAIL w4_a%0d_b%0d_c%0d got cout,sum=%h ovf=%b lat=%0d want %h %b 5",
                     ia, ib, ic, {bus4.cout, bus4.sum}, bus4.overflow, lat, ref_full, ref_ovf);
          end
        end
      end
    end
    $display("op width4 sweep 512 cases, %0d wrong", bad);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    bus8.cin = 1'b0;
    do_op8(8'h05, 8'h07, 1'b0, 1'b1);
    $display("sub a=05 b=07 -> sum=%h cout=%b ovf=%b", r_sum, r_cout, r_ovf);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'hFE, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub_borrow got sum=%h cout=%b ovf=%b want fe 0 0", r_sum, r_cout, r_ovf);
    end
    do_op8(8'h80, 8'h01, 1'b0, 1'b1);
    $display("sub a=80 b=01 -> sum=%h cout=%b ovf=%b", r_sum, r_cout, r_ovf);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h7F, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sub_overflow got sum=%h cout=%b ovf=%b want 7f 1 1", r_sum, r_cout, r_ovf);
    end
    do_op8(8'h05, 8'h07, 1'b0, 1'b0);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h0C, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub0_add got sum=%h cout=%b ovf=%b want 0c 0 0", r_sum, r_cout, r_ovf);
    end
  endtask
`endif

  initial begin
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = 1'b0;
    bus4.sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive4();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
